// File: rtl/csa_resolve_seq.sv
// -----------------------------------------------------------------------------
// csa_resolve_seq
//
// Bit-serial carry-propagate resolver. Takes a carry-save pair (S, C) and
// produces the binary result Y = S + 2*C, one bit position per clock, so no
// wide adder is needed. The block accepts one pair at a time and holds the
// result until the consumer takes it (valid/ready on both sides, no overlap).
//
// Optional feature (compile-time macro CSR_ZERO_SKIP_EN):
//   defined   - a pair with C == 0 goes straight to DONE with Y = {2'b00, S}.
//   undefined - every pair takes the full W+1-cycle serial path.
//   Y is identical in both builds; only latency differs.
//
// Parameters:
//   W          width of S and C; Y is W+2 bits wide
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   S          carry-save sum vector, bit i has weight 2^i
//   C          carry-save carry vector, bit i has weight 2^(i+1)
//   in_valid   S/C valid
//   in_ready   block is idle and can accept a pair
//   Y          resolved result, held stable until next completion or reset
//   out_valid  Y valid
//   out_ready  consumer accepts Y
//   busy       an operation is running or waiting for the consumer
// -----------------------------------------------------------------------------
module csa_resolve_seq #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] S,
    input  logic [W-1:0] C,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W+1:0] Y,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int              CW   = $clog2(W + 1);
    localparam logic [CW-1:0]   LAST = CW'(W);

    state_t        state, state_nxt;
    logic [W:0]    a_sh;       // S operand, shifted right one position per RUN cycle
    logic [W:0]    b_sh;       // C operand pre-shifted by one (its weight), same shifting
    logic [W:0]    sum_sr;     // resolved sum bits, shifted in from the top
    logic [CW-1:0] cnt;        // bit position being resolved
    logic          carry;

    logic accept;
    logic last;
    logic zero_skip;
    logic sum_bit;
    logic carry_nxt;

    assign accept = in_valid && in_ready;
    assign last   = (state == RUN) && (cnt == LAST);

`ifdef CSR_ZERO_SKIP_EN
    assign zero_skip = (C == '0);
`else
    assign zero_skip = 1'b0;
`endif

    // One full-adder slice; bit 0 of each shifter is the current position.
    assign sum_bit   = a_sh[0] ^ b_sh[0] ^ carry;
    assign carry_nxt = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: the default assignment at the top keeps every path assigned, so no
    // latch is inferred for state_nxt.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept)    state_nxt = zero_skip ? DONE : RUN;
            RUN:  if (last)      state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default:             state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode (Moore)
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    // NOTE: the datapath registers are reset along with the FSM so an operation
    // in flight is fully discarded and Y reads 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sr <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            Y      <= '0;
        end else if (accept) begin
            a_sh   <= {1'b0, S};
            b_sh   <= {C, 1'b0};
            sum_sr <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            if (zero_skip) begin
                Y <= {2'b00, S};
            end
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            sum_sr <= {sum_bit, sum_sr[W:1]};
            cnt    <= cnt + 1'b1;
            carry  <= carry_nxt;
            // Final position: the register has W bits so far, this cycle adds
            // bit W and the carry-out becomes the top bit.
            if (last) begin
                Y <= {carry_nxt, sum_bit, sum_sr[W:1]};
            end
        end
    end

endmodule
